// File: rtl/lvds_iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvds_iq_pkg
// Description : Shared types and frame helpers for the LVDS I/Q link.
//               The sequencer state enum, the sync tags and the 32-bit
//               framing used on the serializer words live here.
// Revision    : 1.0 - initial release
// ============================================================================
package lvds_iq_pkg;

  // The 32-bit frame carries two 13-bit rails; the layout is fixed to this.
  localparam int FRAME_IQ_W = 13;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREPARE  = 2'd1,
    TRANSMIT = 2'd2,
    TAIL     = 2'd3
  } tx_state_e;

  localparam logic [1:0]            SYNC_I   = 2'b10;
  localparam logic [1:0]            SYNC_Q   = 2'b01;
  localparam logic [FRAME_IQ_W-1:0] CW_LEVEL = 13'h0FFF;

  // Tail frame: sync tags only, both rails zero with no marker bits.
  localparam logic [31:0] TAIL_FRAME = {SYNC_I, 14'b0, SYNC_Q, 14'b0};

  // Sample frame: I half ends with a 1 marker, Q half ends with a 0 marker.
  function automatic logic [31:0] mk_sample_frame(input logic [FRAME_IQ_W-1:0] i,
                                                  input logic [FRAME_IQ_W-1:0] q);
    return {SYNC_I, i, 1'b1, SYNC_Q, q, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_word_edge.sv
`default_nettype none
// ============================================================================
// Module      : lvds_word_edge
// Description : Turns the serializer's word-completion level into a
//               single-cycle word-boundary strobe (rising-edge detect).
// Revision    : 1.0 - initial release
// Ports       : clk       - clock
//               reset     - synchronous active-high reset
//               tx_done_i - word-completion level from the serializer
//               wb_o      - one-cycle strobe on each rising edge of tx_done_i
// ============================================================================
module lvds_word_edge (
  input  logic clk,
  input  logic reset,
  input  logic tx_done_i,
  output logic wb_o
);

  logic tx_done_q;

  always_ff @(posedge clk) begin
    if (reset) tx_done_q <= 1'b0;
    else       tx_done_q <= tx_done_i;
  end

  assign wb_o = tx_done_i & ~tx_done_q;

endmodule
`default_nettype wire

// File: rtl/iq_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : iq_tx_sequencer
// Description : Paces the signal generator and frames I/Q samples into
//               32-bit sync-tagged words for the LVDS serializer. All state
//               moves happen on serializer word boundaries; a sample slot
//               occurs every skip+2 words, and tail words close a message.
// Revision    : 1.0 - initial release
// Options     : IQ_TX_UNDERRUN_CNT_EN - adds underrun_cnt[15:0], a saturating
//               count of underrun pulses cleared by reset and each start.
// Ports       : clk, reset    - clock, synchronous active-high reset
//               transmit      - level request; a rising edge starts a message
//               abort         - one-cycle pulse, ends the message early
//               speed         - rate select (bit 1: slow pacing)
//               cw            - send constant 13'h0FFF on both rails
//               tx_done       - serializer word-completion level
//               sample_req    - one-cycle request to the generator
//               sample_valid, sample_i, sample_q - generator sample return
//               msg_done      - generator has emitted its last sample
//               tx_data       - word presented to the serializer
//               busy          - high whenever not IDLE
//               underrun      - one-cycle pulse when a sample slot was missed
// ============================================================================
module iq_tx_sequencer
  import lvds_iq_pkg::*;
#(
  parameter int IQ_W       = 13,  // must equal FRAME_IQ_W for the frame layout
  parameter int SKIP_FAST  = 3,
  parameter int SKIP_SLOW  = 8,
  parameter int TAIL_WORDS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            transmit,
  input  logic            abort,
  input  logic [1:0]      speed,
  input  logic            cw,
  input  logic            tx_done,
  output logic            sample_req,
  input  logic            sample_valid,
  input  logic [IQ_W-1:0] sample_i,
  input  logic [IQ_W-1:0] sample_q,
  input  logic            msg_done,
  output logic [31:0]     tx_data,
  output logic            busy,
  output logic            underrun
`ifdef IQ_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]     underrun_cnt
`endif
);

  localparam logic [3:0] SKIP_FAST_C = 4'(SKIP_FAST);
  localparam logic [3:0] SKIP_SLOW_C = 4'(SKIP_SLOW);
  localparam logic [3:0] TAIL_C      = 4'(TAIL_WORDS);

  tx_state_e        state_q, state_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic             hold_valid_q, hold_valid_d;
  logic [IQ_W-1:0]  hold_i_q, hold_i_d;
  logic [IQ_W-1:0]  hold_q_q, hold_q_d;
  logic             done_lat_q, done_lat_d;
  logic             abort_lat_q, abort_lat_d;
  logic             sample_req_q, sample_req_d;
  logic             underrun_q, underrun_d;
  // Two-stage sampler of transmit, clocked only on word boundaries.
  logic             trn_s1_q, trn_s2_q;

  logic             wb;
  logic             start;
  logic [3:0]       skip;
  logic             unused_speed0;

  assign unused_speed0 = speed[0];

  lvds_word_edge u_word_edge (
    .clk       (clk),
    .reset     (reset),
    .tx_done_i (tx_done),
    .wb_o      (wb)
  );

  assign start = trn_s1_q & ~trn_s2_q;
  assign skip  = speed[1] ? SKIP_SLOW_C : SKIP_FAST_C;

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    hold_valid_d = hold_valid_q;
    hold_i_d     = hold_i_q;
    hold_q_d     = hold_q_q;
    done_lat_d   = done_lat_q;
    abort_lat_d  = abort_lat_q;
    underrun_d   = 1'b0;

    if (state_q != IDLE) begin
      if (msg_done) done_lat_d  = 1'b1;
      if (abort)    abort_lat_d = 1'b1;
    end

    if (wb) begin
      case (state_q)
        IDLE: begin
          tx_data_d = '0;
          if (start) begin
            cnt_d   = '0;
            state_d = PREPARE;
          end
        end
        PREPARE: begin
          if (cnt_q == skip) begin
            if (cw) begin
              tx_data_d = mk_sample_frame(CW_LEVEL, CW_LEVEL);
            end else if (hold_valid_q) begin
              tx_data_d = mk_sample_frame(hold_i_q, hold_q_q);
            end else begin
              // Missed sample: keep the link framed with a tail word.
              tx_data_d  = TAIL_FRAME;
              underrun_d = 1'b1;
            end
            hold_valid_d = 1'b0;
            state_d      = TRANSMIT;
          end else begin
            tx_data_d = '0;
            cnt_d     = cnt_q + 4'd1;
          end
        end
        TRANSMIT: begin
          if (done_lat_q || abort_lat_q) begin
            tx_data_d = TAIL_FRAME;
            tcnt_d    = 4'd1;
            state_d   = TAIL;
          end else begin
            tx_data_d = '0;
            cnt_d     = '0;
            state_d   = PREPARE;
          end
        end
        TAIL: begin
          if (tcnt_q < TAIL_C) begin
            tx_data_d = TAIL_FRAME;
            tcnt_d    = tcnt_q + 4'd1;
          end else begin
            tx_data_d    = '0;
            done_lat_d   = 1'b0;
            abort_lat_d  = 1'b0;
            // Drop any late sample so it cannot leak into the next message.
            hold_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A fresh sample beats the consumption clear in the same cycle.
    if (sample_valid && (state_q != IDLE)) begin
      hold_valid_d = 1'b1;
      hold_i_d     = sample_i;
      hold_q_d     = sample_q;
    end

    // One request per PREPARE entry; done_lat_d also covers a msg_done that
    // lands on the same cycle as the TRANSMIT->PREPARE move.
    sample_req_d = (state_d == PREPARE) && (state_q != PREPARE) && !done_lat_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_i_q     <= '0;
      hold_q_q     <= '0;
      done_lat_q   <= 1'b0;
      abort_lat_q  <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      trn_s1_q     <= 1'b0;
      trn_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      hold_valid_q <= hold_valid_d;
      hold_i_q     <= hold_i_d;
      hold_q_q     <= hold_q_d;
      done_lat_q   <= done_lat_d;
      abort_lat_q  <= abort_lat_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      if (wb) begin
        trn_s1_q <= transmit;
        trn_s2_q <= trn_s1_q;
      end
    end
  end

`ifdef IQ_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;
  logic        start_go;

  assign start_go = wb && (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      underrun_cnt_q <= '0;
    end else if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  assign tx_data    = tx_data_q;
  assign busy       = (state_q != IDLE);
  assign underrun   = underrun_q;
  assign sample_req = sample_req_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_tx_sequencer
// Description : Scoreboard bench for iq_tx_sequencer. Stimulus pushes the
//               expected word stream; a monitor pops one entry per word
//               boundary and compares tx_data, busy and underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_tx_sequencer;

  localparam int TAIL_WORDS = 2;
  // Hand-computed frames: {10,I,1,01,Q,0}
  localparam logic [31:0] W_TAIL = 32'h8000_4000;
  localparam logic [31:0] W_SAMP = 32'h8247_7578;  // I=0x0123, Q=0x1ABC
  localparam logic [31:0] W_CW   = 32'h9FFF_5FFE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        transmit = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        cw = 1'b0;
  logic        tx_done = 1'b0;
  logic        sample_valid = 1'b0;
  logic [12:0] sample_i = '0;
  logic [12:0] sample_q = '0;
  logic        msg_done = 1'b0;
  logic        sample_req;
  logic [31:0] tx_data;
  logic        busy;
  logic        underrun;
`ifdef IQ_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  iq_tx_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .transmit     (transmit),
    .abort        (abort),
    .speed        (speed),
    .cw           (cw),
    .tx_done      (tx_done),
    .sample_req   (sample_req),
    .sample_valid (sample_valid),
    .sample_i     (sample_i),
    .sample_q     (sample_q),
    .msg_done     (msg_done),
    .tx_data      (tx_data),
    .busy         (busy),
    .underrun     (underrun)
`ifdef IQ_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        busy;
    logic        ur;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   w_idx = 0;
  int   req_cnt = 0;
  int   gen_cnt = 0;
  int   done_at = 0;
  logic gen_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic b, input logic u);
    exp_t e;
    e.data = d;
    e.busy = b;
    e.ur   = u;
    exp_q.push_back(e);
  endtask

  // Expected word streams for the pieces of a message.
  task automatic exp_start();
    push(32'h0, 1'b0, 1'b0);  // transmit captured, start not yet seen
    push(32'h0, 1'b1, 1'b0);  // IDLE -> PREPARE
  endtask

  task automatic exp_slot(input int skip, input logic [31:0] f, input logic u);
    repeat (skip) push(32'h0, 1'b1, 1'b0);
    push(f, 1'b1, u);
  endtask

  task automatic exp_next();
    push(32'h0, 1'b1, 1'b0);  // TRANSMIT -> PREPARE
  endtask

  task automatic exp_tail();
    repeat (TAIL_WORDS) push(W_TAIL, 1'b1, 1'b0);
    push(32'h0, 1'b0, 1'b0);
  endtask

  // One serializer word: tx_done high for one cycle, four cycles per word.
  task automatic do_wb();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic run();
    int budget;
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      do_wb();
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_abort();
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  // Monitor: the bench's own word-boundary detector.
  logic m_prev = 1'b0;
  logic m_wb = 1'b0;
  always @(posedge clk) begin
    m_wb   = tx_done && !m_prev;
    m_prev = tx_done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sample_req) req_cnt++;
    if (m_wb) begin
      w_idx++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word[%0d]: got %h, required no word", w_idx, tx_data);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("tx_data[%0d]", w_idx), tx_data, e.data);
        check($sformatf("busy[%0d]", w_idx), {31'b0, busy}, {31'b0, e.busy});
        check($sformatf("underrun[%0d]", w_idx), {31'b0, underrun}, {31'b0, e.ur});
      end
    end else if (!reset && underrun) begin
      check("stray_underrun", {31'b0, underrun}, 32'h0);
    end
  end

  // Generator model: answers each request two cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (sample_req && gen_en) begin
        repeat (2) @(posedge clk);
        #1;
        gen_cnt++;
        sample_valid = 1'b1;
        sample_i     = 13'h0123;
        sample_q     = 13'h1ABC;
        msg_done     = (gen_cnt == done_at);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        msg_done     = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_data", tx_data, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_sample_req", {31'b0, sample_req}, 32'h0);
    check("reset_underrun", {31'b0, underrun}, 32'h0);
    reset = 1'b0;
    @(posedge clk);

    // Fast pacing, three samples, msg_done with the third.
    speed = 2'b00; gen_en = 1'b1; gen_cnt = 0; done_at = 3;
    r0 = req_cnt;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;  // falling mid-message must not stop it
    exp_slot(3, W_SAMP, 1'b0); exp_next();
    exp_slot(3, W_SAMP, 1'b0); exp_next();
    exp_slot(3, W_SAMP, 1'b0);
    exp_tail();
    push(32'h0, 1'b0, 1'b0);
    push(32'h0, 1'b0, 1'b0);
    run();
    check("fast_req_count", 32'(req_cnt - r0), 32'd3);

    // Slow pacing, two samples.
    speed = 2'b10; gen_cnt = 0; done_at = 2;
    r0 = req_cnt;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;
    exp_slot(8, W_SAMP, 1'b0); exp_next();
    exp_slot(8, W_SAMP, 1'b0);
    exp_tail();
    run();
    check("slow_req_count", 32'(req_cnt - r0), 32'd2);

    // Silent generator: every slot becomes an underrun tail.
    speed = 2'b00; gen_en = 1'b0; cw = 1'b0;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;
    exp_slot(3, W_TAIL, 1'b1); exp_next();
    exp_slot(3, W_TAIL, 1'b1); exp_next();
    run();
`ifdef IQ_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_2", {16'h0, underrun_cnt}, 32'd2);
`endif
    pulse_abort();
    exp_slot(3, W_TAIL, 1'b1);
    exp_tail();
    run();
`ifdef IQ_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_3", {16'h0, underrun_cnt}, 32'd3);
`endif

    // CW mode with silent generator: constant frames, no underrun.
    cw = 1'b1;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;
    exp_slot(3, W_CW, 1'b0); exp_next();
    run();
    pulse_abort();
    exp_slot(3, W_CW, 1'b0);
    exp_tail();
    run();
`ifdef IQ_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_cleared", {16'h0, underrun_cnt}, 32'd0);
`endif
    cw = 1'b0;

    // Abort in PREPARE, then reset in the middle of TAIL.
    gen_en = 1'b1; gen_cnt = 0; done_at = 0;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;
    exp_slot(3, W_SAMP, 1'b0); exp_next();
    run();
    pulse_abort();
    exp_slot(3, W_SAMP, 1'b0);
    push(W_TAIL, 1'b1, 1'b0);
    run();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midtail_reset_tx_data", tx_data, 32'h0);
    check("midtail_reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    @(posedge clk);

    // Recovery after reset: one-sample message.
    gen_cnt = 0; done_at = 1;
    r0 = req_cnt;
    transmit = 1'b1;
    exp_start();
    run();
    transmit = 1'b0;
    exp_slot(3, W_SAMP, 1'b0);
    exp_tail();
    run();
    check("recovery_req_count", 32'(req_cnt - r0), 32'd1);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
